// File: rtl/matrix_mult_accel.sv
// matrix_mult_accel: streaming integer matrix multiply, C = A x B.
//   A is d0 x d1 and B is d1 x d2. Both are streamed in row-major order into
//   on-chip buffers. The element loop then runs INIT/MAC/OUT once per C[i][j],
//   in row-major order. Each result appears for one cycle with valid, and a
//   done pulse follows the last element.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start           job request, sampled only in IDLE
//   abufdatain      A element stream (n bits)
//   bbufdatain      B element stream (n bits)
//   d0, d1, d2      dimensions, latched on the start edge
//   valid           one-cycle pulse; result holds C[i][j]
//   result          2n-bit product element, modulo 2^(2n)
//   done            one-cycle pulse at job end
module matrix_mult_accel #(
  parameter int n = 8,
  parameter int m = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   abufdatain,
  input  logic [n-1:0]   bbufdatain,
  input  logic [n-1:0]   d0,
  input  logic [n-1:0]   d1,
  input  logic [n-1:0]   d2,
  output logic           valid,
  output logic [2*n-1:0] result,
  output logic           done
);

  localparam int W = 2 * n;
  localparam logic [n-1:0] NONE = 1;
  localparam logic [m-1:0] AONE = 1;
  localparam logic [W-1:0] WONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_INIT, S_MAC, S_OUT, S_DONE
  } state_t;

  state_t         state_q;
  logic [n-1:0]   d0_q, d1_q, d2_q;
  logic [W-1:0]   lcnt_q;
  logic [n-1:0]   i_q, j_q, k_q;
  logic [m-1:0]   arow_q;            // i*d1, the A address of row i, k=0
  logic [m-1:0]   aptr_q, bptr_q;    // read addresses fed to the buffers
  logic [W-1:0]   acc_q;
  logic [W-1:0]   result_q;
  logic           valid_q, done_q;

  logic [n-1:0]   abuf [2**m];
  logic [n-1:0]   bbuf [2**m];
  logic [n-1:0]   rda_q, rdb_q;

  logic [W-1:0]   na, nb, lmax;
  logic [W-1:0]   prod, acc_d;
  logic           last_k, last_j, last_i;

  // Stream lengths; LOAD runs for the longer of the two.
  always_comb begin
    na     = W'(d0_q) * W'(d1_q);
    nb     = W'(d1_q) * W'(d2_q);
    lmax   = (na > nb) ? na : nb;
    prod   = W'(rda_q) * W'(rdb_q);
    acc_d  = acc_q + prod;
    last_k = (k_q == d1_q - NONE);
    last_j = (j_q == d2_q - NONE);
    last_i = (i_q == d0_q - NONE);
  end

  // Buffers: written only in LOAD. Each stream stops once its own count is
  // reached. Reads are registered every cycle. INIT absorbs the one-cycle
  // latency, so MAC cycle k sees the operands for k.
  always_ff @(posedge clk) begin
    if (rst && state_q == S_LOAD) begin
      if (lcnt_q < na) abuf[m'(lcnt_q)] <= abufdatain;
      if (lcnt_q < nb) bbuf[m'(lcnt_q)] <= bbufdatain;
    end
    rda_q <= abuf[aptr_q];
    rdb_q <= bbuf[bptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      lcnt_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      arow_q   <= '0;
      aptr_q   <= '0;
      bptr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            d0_q   <= d0;
            d1_q   <= d1;
            d2_q   <= d2;
            lcnt_q <= '0;
            // An empty product skips straight to the done pulse.
            if (d0 == '0 || d1 == '0 || d2 == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: state_q <= S_LOAD;
        S_LOAD: begin
          lcnt_q <= lcnt_q + WONE;
          if (lcnt_q == lmax - WONE) begin
            state_q <= S_INIT;
            i_q     <= '0;
            j_q     <= '0;
            arow_q  <= '0;
            aptr_q  <= '0;
            bptr_q  <= '0;
          end
        end
        S_INIT: begin
          acc_q   <= '0;
          k_q     <= '0;
          aptr_q  <= aptr_q + AONE;
          bptr_q  <= bptr_q + m'(d2_q);
          state_q <= S_MAC;
        end
        S_MAC: begin
          acc_q  <= acc_d;
          k_q    <= k_q + NONE;
          aptr_q <= aptr_q + AONE;
          bptr_q <= bptr_q + m'(d2_q);
          // The final term is folded in directly so that result is ready in OUT.
          if (last_k) begin
            result_q <= acc_d;
            valid_q  <= 1'b1;
            state_q  <= S_OUT;
          end
        end
        S_OUT: begin
          if (last_j) begin
            j_q <= '0;
            if (last_i) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              i_q     <= i_q + NONE;
              arow_q  <= arow_q + m'(d1_q);
              aptr_q  <= arow_q + m'(d1_q);
              bptr_q  <= '0;
              state_q <= S_INIT;
            end
          end else begin
            j_q     <= j_q + NONE;
            aptr_q  <= arow_q;
            bptr_q  <= m'(j_q) + AONE;
            state_q <= S_INIT;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign valid  = valid_q;
  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_matrix_mult_accel.sv
module tb_matrix_mult_accel;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  abuf = '0, bbuf = '0, d0 = '0, d1 = '0, d2 = '0;
  logic        valid, done;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  int          am [64];
  int          bm [64];
  logic [15:0] sb [$];          // expected results, in output order
  int          vcyc [$];
  logic [15:0] vres [$];
  int          done_cnt, done_cyc;

  matrix_mult_accel #(.n(8), .m(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .abufdatain(abuf), .bbufdatain(bbuf),
    .d0(d0), .d1(d1), .d2(d2),
    .valid(valid), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] cval(input int i, input int j, input int a1, input int a2);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < a1; k++) s = s + 16'(am[i*a1+k] * bm[k*a2+j]);
    return s;
  endfunction

  task automatic push_model(input int a0, input int a1, input int a2);
    for (int i = 0; i < a0; i++)
      for (int j = 0; j < a2; j++) sb.push_back(cval(i, j, a1, a2));
  endtask

  task automatic load_basic();
    for (int t = 0; t < 10; t++) am[t] = t + 1;
    for (int t = 0; t < 15; t++) bm[t] = (t % 3) + 1;
  endtask

  // Start pulse, streams, and capture of every valid/done. Cycle c=0 is the
  // cycle right after the start edge. inj >= 0 pulses start at cycle inj.
  task automatic run_job(input int a0, input int a1, input int a2, input int inj);
    int na, nb, len, budget;
    na = a0 * a1;
    nb = a1 * a2;
    len = (na > nb) ? na : nb;
    budget = len + a0 * a2 * (a1 + 2) + 12;
    vcyc.delete(); vres.delete();
    done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; d0 = 8'(a0); d1 = 8'(a1); d2 = 8'(a2);
    @(posedge clk); #1;
    start = 1'b0;
    fork
      begin
        if (len > 0) begin
          @(posedge clk); #1;
          for (int t = 0; t < len; t++) begin
            abuf = (t < na) ? 8'(am[t]) : 8'h00;
            bbuf = (t < nb) ? 8'(bm[t]) : 8'h00;
            @(posedge clk); #1;
          end
          abuf = '0; bbuf = '0;
        end
      end
      begin
        for (int c = 0; c < budget; c++) begin
          @(negedge clk);
          if (valid) begin vcyc.push_back(c); vres.push_back(result); end
          if (done) begin done_cnt++; done_cyc = c; end
          if (c == inj) start = 1'b1;
          else if (c == inj + 1) start = 1'b0;
        end
      end
    join
  endtask

  task automatic test_reset();
    int nv, nd;
    rst = 1'b0; start = 1'b1; d0 = 8'd2; d1 = 8'd2; d2 = 8'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
    start = 1'b0; rst = 1'b1;
    nv = 0; nd = 0;
    repeat (10) begin @(negedge clk); if (valid) nv++; if (done) nd++; end
    checks++; if (nv != 0 || nd != 0) begin errors++; $display("FAIL reset_nojob valids=%0d dones=%0d exp=0/0", nv, nd); end
  endtask

  task automatic test_basic();
    logic [15:0] e;
    load_basic();
    push_model(2, 5, 3);
    run_job(2, 5, 3, -1);
    checks++; if (vres.size() != 6) begin errors++; $display("FAIL basic_count got=%0d exp=6", vres.size()); end
    foreach (vres[x]) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL basic_extra got=%h exp=none", vres[x]); end
      else begin
        e = sb.pop_front();
        if (vres[x] !== e) begin errors++; $display("FAIL basic_result[%0d] got=%0d exp=%0d", x, vres[x], e); end
      end
    end
    checks++; if (vcyc.size() > 0 && vcyc[0] != 22) begin errors++; $display("FAIL basic_first_cycle got=%0d exp=22", vcyc[0]); end
    for (int x = 1; x < vcyc.size(); x++) begin
      checks++;
      if (vcyc[x] - vcyc[x-1] != 7) begin errors++; $display("FAIL basic_pitch[%0d] got=%0d exp=7", x, vcyc[x]-vcyc[x-1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (vcyc.size() == 0 || done_cyc != vcyc[vcyc.size()-1] + 1) begin
      errors++; $display("FAIL basic_done_cycle got=%0d exp=last_valid+1", done_cyc);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_missing got=%0d exp=0 left", sb.size()); end
    sb.delete();
  endtask

  task automatic test_width();
    logic [15:0] e;
    am[0] = 255; bm[0] = 255;
    push_model(1, 1, 1);
    run_job(1, 1, 1, -1);
    checks++; if (vres.size() != 1) begin errors++; $display("FAIL w1_count got=%0d exp=1", vres.size()); end
    else begin
      e = sb.pop_front();
      checks++; if (vres[0] !== e) begin errors++; $display("FAIL w1_result got=%h exp=%h", vres[0], e); end
      checks++; if (vres[0] !== 16'hFE01) begin errors++; $display("FAIL w1_const got=%h exp=fe01", vres[0]); end
    end
    checks++; if (done_cnt != 1 || done_cyc != 5) begin errors++; $display("FAIL w1_done cnt=%0d cyc=%0d exp=1/5", done_cnt, done_cyc); end
    sb.delete();
    am[0] = 255; am[1] = 255; bm[0] = 255; bm[1] = 255;
    push_model(1, 2, 1);
    run_job(1, 2, 1, -1);
    checks++; if (vres.size() != 1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", vres.size()); end
    else begin
      e = sb.pop_front();
      checks++; if (vres[0] !== e) begin errors++; $display("FAIL wrap_result got=%h exp=%h", vres[0], e); end
      checks++; if (vres[0] !== 16'hFC02) begin errors++; $display("FAIL wrap_const got=%h exp=fc02", vres[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
    sb.delete();
  endtask

  task automatic test_zero_dim();
    logic [15:0] e;
    run_job(2, 0, 3, -1);
    checks++; if (vres.size() != 0) begin errors++; $display("FAIL zero_valid got=%0d exp=0", vres.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc != 0) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=0", done_cyc); end
    // Follow-up job must run normally.
    load_basic();
    am[0] = 7; bm[4] = 9;
    push_model(2, 5, 3);
    run_job(2, 5, 3, -1);
    checks++; if (vres.size() != 6) begin errors++; $display("FAIL zero_next_count got=%0d exp=6", vres.size()); end
    foreach (vres[x]) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL zero_next_extra got=%h exp=none", vres[x]); end
      else begin
        e = sb.pop_front();
        if (vres[x] !== e) begin errors++; $display("FAIL zero_next_result[%0d] got=%0d exp=%0d", x, vres[x], e); end
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_next_done got=%0d exp=1", done_cnt); end
    sb.delete();
  endtask

  task automatic test_ignored_start();
    logic [15:0] e;
    load_basic();
    push_model(2, 5, 3);
    run_job(2, 5, 3, 19);
    checks++; if (vres.size() != 6) begin errors++; $display("FAIL ign_count got=%0d exp=6", vres.size()); end
    foreach (vres[x]) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL ign_extra got=%h exp=none", vres[x]); end
      else begin
        e = sb.pop_front();
        if (vres[x] !== e) begin errors++; $display("FAIL ign_result[%0d] got=%0d exp=%0d", x, vres[x], e); end
      end
    end
    checks++; if (vcyc.size() > 0 && vcyc[0] != 22) begin errors++; $display("FAIL ign_first_cycle got=%0d exp=22", vcyc[0]); end
    checks++; if (done_cnt != 1 || done_cyc != 58) begin errors++; $display("FAIL ign_done cnt=%0d cyc=%0d exp=1/58", done_cnt, done_cyc); end
    sb.delete();
  endtask

  task automatic test_abort();
    int nv, nd;
    load_basic();
    @(posedge clk); #1;
    start = 1'b1; d0 = 8'd2; d1 = 8'd5; d2 = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      abuf = 8'h11; bbuf = 8'h22;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL abort_result got=%h exp=0000", result); end
    rst = 1'b1; abuf = '0; bbuf = '0;
    nv = 0; nd = 0;
    repeat (80) begin @(negedge clk); if (valid) nv++; if (done) nd++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", nv); end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width();
    test_zero_dim();
    test_ignored_start();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_mult_accel.md
Name: matrix_mult_accel

Overview:
- Streaming integer matrix-multiply accelerator: C = A × B, where A is d0×d1 and B is d1×d2.
- Internals: an input handler writes the serial A and B streams into two on-chip buffers. A controller FSM sequences multiply-accumulate passes over the buffers. A datapath holds the buffers, the dimension registers, the MAC and the result register.
- Results leave one element per valid pulse, in row-major order, followed by a done pulse.

Parameters:
- n, 8: element width of A, B and the dimension inputs.
- m, 10: buffer address width; each buffer holds 2^m elements.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low.
- start  input  1  one-cycle request to begin a job; sampled only in IDLE.
- abufdatain  input  n  A element stream, row-major (A[i][k] at address i*d1+k).
- bbufdatain  input  n  B element stream, row-major (B[k][j] at address k*d2+j).
- d0  input  n  rows of A; latched on the start edge.
- d1  input  n  columns of A = rows of B; latched on the start edge.
- d2  input  n  columns of B; latched on the start edge.
- valid  output  1  one-cycle pulse; result holds C[i][j].
- result  output  2n  product element, unsigned, modulo 2^(2n).
- done  output  1  one-cycle pulse at job end.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE.
  - valid=0, done=0, result=0.
  - Dimension registers, accumulator and address counters are cleared.
  - Buffer contents are not cleared.
  - Reset applied mid-job aborts the job immediately; no further valid or done is produced.
- FSM states: IDLE, WAIT, LOAD, INIT, MAC, OUT, DONE.
- IDLE:
  - On start=1 at edge N: latch d0/d1/d2 and go to WAIT.
  - If any latched dimension is 0: go directly to DONE; no valid is produced.
- WAIT: one cycle; no data is sampled.
- LOAD:
  - First stream samples are taken at edge N+2.
  - Each edge samples abufdatain into A-buffer address a (0..d0*d1-1) and bbufdatain into B-buffer address b (0..d1*d2-1). Both counters advance together.
  - Each stream stops writing once its count is reached.
  - LOAD lasts max(d0*d1, d1*d2) edges, then goes to INIT.
- Output element loop, row-major over i in 0..d0-1, j in 0..d2-1:
  - INIT, 1 cycle: clear the accumulator and present read addresses for k=0.
  - MAC, d1 cycles: acc += A[i][k]*B[k][j], k = 0..d1-1. The n×n unsigned product is 2n bits; the accumulator is 2n bits and wraps modulo 2^(2n).
  - OUT, 1 cycle: result <= acc and valid=1 for this one cycle.
  - Element pitch is d1+2 cycles.
  - After the last element, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- result holds its last value between valid pulses and after done, until reset or the next OUT.
- start is ignored outside IDLE. Dimension inputs are only sampled on the start edge.
- Callers must keep d0*d1 ≤ 2^m and d1*d2 ≤ 2^m. Beyond that, buffer addresses wrap modulo 2^m; this is not an error.
- Buffer reads are registered, with 1-cycle latency absorbed by INIT. Writes and reads never coincide.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 → valid=0, done=0, result=0; no job starts.
- Basic job, d0=2, d1=5, d2=3:
  - Stimulus: start pulse, then A stream 1..10 and B stream with B[k][j]=j+1 (1,2,3 repeated 5 times) over 15 cycles; the A stream stops after 10.
  - Required: 6 valid pulses spaced 7 cycles apart with results 15, 30, 45, 40, 80, 120, then a done pulse on the cycle after the last valid.
- Width and wrap:
  - d0=d1=d2=1, A=B=0xFF → result 0xFE01.
  - d0=1, d1=2, d2=1, all elements 0xFF → result 0xFC02 (sum wraps modulo 2^16).
- Zero dimension: d1=0 with a start pulse → no valid; done pulses once; FSM returns to IDLE and accepts a following job normally.
- Ignored start and abort:
  - A start pulse during MAC of a 2×5×3 job does not alter its results.
  - rst=0 asserted during LOAD → no valid or done follows, and outputs are 0 on the next edge.
